// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA box renderer: default visible area,
// the square's colour palette and the per-axis bounce direction.
package vga_pkg;

    localparam int H_VIS_DEFAULT = 640;
    localparam int V_VIS_DEFAULT = 480;

    typedef logic [11:0] rgb_t;

    // Colour sequence stepped through on every bounce, RGB 4:4:4.
    localparam rgb_t PALETTE [0:7] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'h0FF, 12'hF0F, 12'hFFF, 12'hF80
    };

    typedef enum logic {INC, DEC} dir_t;

    function automatic rgb_t palette_lookup(input logic [2:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_box_renderer_if.sv
// Pixel-stream bundle between the sync generator, the box renderer and the DAC.
interface vga_box_renderer_if;
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
    logic       hSynchIn;
    logic       vSynchIn;
    logic       hSynch;
    logic       vSynch;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       frameTick;

    modport master (
        output en, x, y, hSynchIn, vSynchIn,
        input  hSynch, vSynch, red, green, blue, frameTick
    );

    modport slave (
        input  en, x, y, hSynchIn, vSynchIn,
        output hSynch, vSynch, red, green, blue, frameTick
    );
endinterface

// File: rtl/bounce_axis.sv
// One axis of the bouncing square: position register plus INC/DEC direction
// FSM. The square's far edge is clamped to LIMIT and its near edge to 0; hit
// flags the step on which a clamp and direction flip take place.
module bounce_axis
    import vga_pkg::*;
#(
    parameter int LIMIT = 640,
    parameter int SIZE  = 32,
    parameter int SPEED = 2,
    parameter int INIT  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [9:0] pos,
    output logic       hit
);

    localparam logic [10:0] MAX_POS = 11'(LIMIT - SIZE);

    dir_t        dir;
    logic [10:0] pos_ext;
    logic [10:0] pos_inc;
    logic        at_edge;

    assign pos_ext = {1'b0, pos};
    assign pos_inc = pos_ext + 11'(SPEED);
    assign at_edge = (dir == INC) ? (pos_inc >= MAX_POS) : (pos_ext <= 11'(SPEED));
    assign hit     = step && at_edge;

    // Direction FSM and position: move by SPEED per step, clamp and flip at the edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= 10'(INIT);
            dir <= INC;
        end else if (step) begin
            case (dir)
                INC: begin
                    if (at_edge) begin
                        pos <= MAX_POS[9:0];
                        dir <= DEC;
                    end else begin
                        pos <= pos_inc[9:0];
                    end
                end
                DEC: begin
                    if (at_edge) begin
                        pos <= 10'd0;
                        dir <= INC;
                    end else begin
                        pos <= pos - 10'(SPEED);
                    end
                end
                default: dir <= INC;
            endcase
        end
    end

endmodule

// File: rtl/vga_box_renderer.sv
// Pixel stage behind the 640x480 sync generator: draws a bouncing square on a
// background, recolouring it on each bounce, and re-times sync by one clock so
// sync and RGB leave together.
module vga_box_renderer
    import vga_pkg::*;
#(
    parameter int         H_VIS    = H_VIS_DEFAULT,
    parameter int         V_VIS    = V_VIS_DEFAULT,
    parameter int         BOX_SIZE = 32,
    parameter int         SPEED    = 2,
    parameter int         X0       = 100,
    parameter int         Y0       = 100,
    parameter logic [11:0] BG_COLOR = 12'h113
) (
    input logic               clk,
    input logic               rst,
    vga_box_renderer_if.slave bus
);

    logic [9:0]  box_x;
    logic [9:0]  box_y;
    logic        hit_x;
    logic        hit_y;
    logic [2:0]  color_idx;
    logic [11:0] rgb;
    logic        h_sync;
    logic        v_sync;
    logic        frame_tick;

    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic [10:0] bx_ext;
    logic [10:0] by_ext;
    logic        visible;
    logic        in_box;
    logic        upd;
    logic        step;

    // Comparisons run in 11 bits so box_x + BOX_SIZE never wraps.
    assign x_ext   = {1'b0, bus.x};
    assign y_ext   = {1'b0, bus.y};
    assign bx_ext  = {1'b0, box_x};
    assign by_ext  = {1'b0, box_y};
    assign visible = (x_ext < 11'(H_VIS)) && (y_ext < 11'(V_VIS));
    assign in_box  = (x_ext >= bx_ext) && (x_ext < bx_ext + 11'(BOX_SIZE)) &&
                     (y_ext >= by_ext) && (y_ext < by_ext + 11'(BOX_SIZE));

    // First clock of the first blanking line: once per frame, never visible.
    assign upd  = (bus.x == 10'd0) && (bus.y == 10'(V_VIS));
    assign step = upd && bus.en;

    function automatic logic [11:0] pixel_color(input logic vis, input logic inb,
                                                input logic [2:0] idx);
        if (!vis)
            return 12'h000;
        else if (inb)
            return palette_lookup(idx);
        else
            return BG_COLOR;
    endfunction

    bounce_axis #(
        .LIMIT (H_VIS),
        .SIZE  (BOX_SIZE),
        .SPEED (SPEED),
        .INIT  (X0)
    ) u_x (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .pos  (box_x),
        .hit  (hit_x)
    );

    bounce_axis #(
        .LIMIT (V_VIS),
        .SIZE  (BOX_SIZE),
        .SPEED (SPEED),
        .INIT  (Y0)
    ) u_y (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .pos  (box_y),
        .hit  (hit_y)
    );

    // Output registers: pixel colour, delayed sync, frame tick and palette index.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb        <= 12'h000;
            h_sync     <= 1'b1;
            v_sync     <= 1'b1;
            frame_tick <= 1'b0;
            color_idx  <= 3'd0;
        end else begin
            rgb        <= pixel_color(visible, in_box, color_idx);
            h_sync     <= bus.hSynchIn;
            v_sync     <= bus.vSynchIn;
            frame_tick <= upd;
            if (hit_x || hit_y)
                color_idx <= color_idx + 3'd1;
        end
    end

    assign bus.red       = rgb[11:8];
    assign bus.green     = rgb[7:4];
    assign bus.blue      = rgb[3:0];
    assign bus.hSynch    = h_sync;
    assign bus.vSynch    = v_sync;
    assign bus.frameTick = frame_tick;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Bench for vga_box_renderer: directed steps plus randomized pixels and frame
// events, checked against a behavioural model of the bouncing square.
module tb_vga_box_renderer;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    vga_box_renderer_if bus0 ();
    vga_box_renderer_if bus1 ();

    assign bus1.en       = bus0.en;
    assign bus1.x        = bus0.x;
    assign bus1.y        = bus0.y;
    assign bus1.hSynchIn = bus0.hSynchIn;
    assign bus1.vSynchIn = bus0.vSynchIn;

    // Instance 0 uses the default start; instance 1 starts so that both axes
    // reach the bottom-right corner on the same frame.
    vga_box_renderer dut (.clk(clk), .rst(rst), .bus(bus0));
    vga_box_renderer #(.X0(576), .Y0(416)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] pal [0:7];
    int start_x [0:1];
    int start_y [0:1];
    int m_pos [0:1][0:1];
    int m_dir [0:1][0:1];
    int m_col [0:1];
    bit m_corner [0:1];
    bit m_xflip0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pos[k][0] = start_x[k];
            m_pos[k][1] = start_y[k];
            m_dir[k][0] = 1;
            m_dir[k][1] = 1;
            m_col[k]    = 0;
            m_corner[k] = 0;
        end
        m_xflip0 = 0;
    endtask

    // One frame event: each axis moves 2 px toward its edge; reaching an edge
    // pins the square there and reverses it. Any bounce advances the colour once.
    task automatic model_event(input bit e);
        int lim;
        int hits;
        for (int k = 0; k < 2; k++) begin
            hits = 0;
            m_corner[k] = 0;
            if (k == 0) m_xflip0 = 0;
            if (e) begin
                for (int a = 0; a < 2; a++) begin
                    lim = (a == 0) ? 640 - 32 : 480 - 32;
                    if (m_dir[k][a] > 0) begin
                        if (m_pos[k][a] + 2 >= lim) begin
                            m_pos[k][a] = lim; m_dir[k][a] = -1; hits++;
                            if (k == 0 && a == 0) m_xflip0 = 1;
                        end else m_pos[k][a] += 2;
                    end else begin
                        if (m_pos[k][a] <= 2) begin
                            m_pos[k][a] = 0; m_dir[k][a] = 1; hits++;
                        end else m_pos[k][a] -= 2;
                    end
                end
                if (hits != 0) m_col[k] = (m_col[k] + 1) % 8;
                m_corner[k] = (hits == 2);
            end
        end
    endtask

    function automatic logic [11:0] exp_rgb(input int k, input int px, input int py);
        if (px >= 640 || py >= 480) return 12'h000;
        if (px >= m_pos[k][0] && px < m_pos[k][0] + 32 &&
            py >= m_pos[k][1] && py < m_pos[k][1] + 32) return pal[m_col[k]];
        return 12'h113;
    endfunction

    task automatic check_pixel(input string tag, input int px, input int py);
        bus0.x = 10'(px);
        bus0.y = 10'(py);
        tick();
        chk({tag, "_rgb0"}, 32'({bus0.red, bus0.green, bus0.blue}), 32'(exp_rgb(0, px, py)));
        chk({tag, "_rgb1"}, 32'({bus1.red, bus1.green, bus1.blue}), 32'(exp_rgb(1, px, py)));
    endtask

    task automatic check_state(input string tag, input int k);
        logic [9:0] bx, by;
        logic [2:0] ci;
        dir_t dx, dy;
        if (k == 0) begin
            bx = dut.box_x; by = dut.box_y; ci = dut.color_idx;
            dx = dut.u_x.dir; dy = dut.u_y.dir;
        end else begin
            bx = dut1.box_x; by = dut1.box_y; ci = dut1.color_idx;
            dx = dut1.u_x.dir; dy = dut1.u_y.dir;
        end
        chk({tag, "_box_x"}, 32'(bx), 32'(m_pos[k][0]));
        chk({tag, "_box_y"}, 32'(by), 32'(m_pos[k][1]));
        chk({tag, "_color"}, 32'(ci), 32'(m_col[k]));
        chk({tag, "_dir_x"}, 32'(dx), 32'((m_dir[k][0] > 0) ? INC : DEC));
        chk({tag, "_dir_y"}, 32'(dy), 32'((m_dir[k][1] > 0) ? INC : DEC));
    endtask

    task automatic frame_event(input bit e);
        bus0.en = e;
        bus0.x  = 10'd0;
        bus0.y  = 10'd480;
        tick();
        model_event(e);
        chk("frame_tick_hi", 32'(bus0.frameTick), 32'd1);
        bus0.x = 10'd1;
        tick();
        chk("frame_tick_lo", 32'(bus0.frameTick), 32'd0);
    endtask

    task automatic random_pixel(input string tag);
        int px, py, k;
        k = int'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 0) begin
            px = int'($urandom_range(0, 1023));
            py = int'($urandom_range(0, 1023));
        end else begin
            px = (m_pos[k][0] + int'($urandom_range(0, 40)) - 4 + 1024) % 1024;
            py = (m_pos[k][1] + int'($urandom_range(0, 40)) - 4 + 1024) % 1024;
        end
        if (px == 0 && py == 480) px = 1;
        check_pixel(tag, px, py);
    endtask

    initial begin
        int guard;
        pal[0] = 12'hF00; pal[1] = 12'h0F0; pal[2] = 12'h00F; pal[3] = 12'hFF0;
        pal[4] = 12'h0FF; pal[5] = 12'hF0F; pal[6] = 12'hFFF; pal[7] = 12'hF80;
        start_x[0] = 100; start_y[0] = 100;
        start_x[1] = 576; start_y[1] = 416;
        model_reset();

        // Reset with sync inputs low: outputs must still show inactive sync.
        bus0.en = 1'b0; bus0.x = 10'd100; bus0.y = 10'd100;
        bus0.hSynchIn = 1'b0; bus0.vSynchIn = 1'b0;
        rst = 1'b1;
        tick(); tick();
        chk("rst_rgb", 32'({bus0.red, bus0.green, bus0.blue}), 32'h000);
        chk("rst_hsync", 32'(bus0.hSynch), 32'd1);
        chk("rst_vsync", 32'(bus0.vSynch), 32'd1);
        chk("rst_ftick", 32'(bus0.frameTick), 32'd0);
        check_state("rst0", 0);
        check_state("rst1", 1);
        rst = 1'b0;
        bus0.hSynchIn = 1'b1; bus0.vSynchIn = 1'b1;

        // Basic pixel classes with motion disabled.
        check_pixel("box_corner", 100, 100);
        check_pixel("left_of_box", 99, 100);
        check_pixel("h_blank", 640, 10);
        check_pixel("box_last", 131, 131);
        check_pixel("below_box", 131, 132);
        check_pixel("v_blank", 10, 480);

        // Sync is a one-clock delay.
        chk("hsync_idle", 32'(bus0.hSynch), 32'd1);
        bus0.hSynchIn = 1'b0;
        chk("hsync_pre", 32'(bus0.hSynch), 32'd1);
        tick();
        chk("hsync_fall", 32'(bus0.hSynch), 32'd0);
        bus0.hSynchIn = 1'b1; bus0.vSynchIn = 1'b0;
        tick();
        chk("hsync_rise", 32'(bus0.hSynch), 32'd1);
        chk("vsync_fall", 32'(bus0.vSynch), 32'd0);
        bus0.vSynchIn = 1'b1;
        tick();
        chk("vsync_rise", 32'(bus0.vSynch), 32'd1);

        // Frame event with motion held, then one with motion enabled.
        chk("ftick_idle", 32'(bus0.frameTick), 32'd0);
        frame_event(1'b0);
        check_state("hold0", 0);
        frame_event(1'b1);
        check_state("move0", 0);
        check_state("move1", 1);

        // Run frames until instance 0 bounces off the right edge; instance 1
        // meets the corner along the way. Pixels are sampled in between.
        guard = 0;
        while (!m_xflip0 && guard < 2000) begin
            frame_event(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            if (m_corner[1]) begin
                check_state("corner1", 1);
                chk("corner1_pos", 32'(dut1.box_x) << 16 | 32'(dut1.box_y), (32'd608 << 16) | 32'd448);
            end
            if (guard % 8 == 0) begin
                check_state("run0", 0);
                check_state("run1", 1);
            end
            random_pixel("run_px");
            guard++;
        end
        chk("xflip_reached", 32'(m_xflip0), 32'd1);
        check_state("xflip0", 0);
        chk("xflip0_pos", 32'(dut.box_x), 32'd608);
        frame_event(1'b1);
        check_state("after_flip0", 0);
        chk("after_flip0_pos", 32'(dut.box_x), 32'd606);
        for (int i = 0; i < 12; i++) random_pixel("post_px");

        // Reset in the middle of a visible line with the square mid-screen.
        bus0.x = 10'(m_pos[0][0] + 5);
        bus0.y = 10'(m_pos[0][1] + 5);
        bus0.hSynchIn = 1'b0; bus0.vSynchIn = 1'b0;
        rst = 1'b1;
        tick();
        model_reset();
        chk("midrst_rgb", 32'({bus0.red, bus0.green, bus0.blue}), 32'h000);
        chk("midrst_hsync", 32'(bus0.hSynch), 32'd1);
        chk("midrst_vsync", 32'(bus0.vSynch), 32'd1);
        check_state("midrst0", 0);
        check_state("midrst1", 1);
        rst = 1'b0;
        bus0.hSynchIn = 1'b1; bus0.vSynchIn = 1'b1;
        check_pixel("midrst_draw", 100, 100);
        check_pixel("midrst_draw1", 580, 420);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
